// File: rtl/fila_requisicoes.sv
// -----------------------------------------------------------------------------
// fila_requisicoes
//
// Request queue in front of gerenciador_ativos. It buffers update (atualizar)
// and deactivate (desativar) requests and issues them as one-cycle command
// pulses, one per cycle, in FIFO order. A request is issued no earlier than
// the cycle after it is accepted.
//
// Optional feature (macro FILA_REQUISICOES_COALESCE_EN):
//   When defined, an accepted atualizar whose address matches an atualizar
//   entry that is still queued (not the head being popped this cycle)
//   overwrites that entry's predecessor in place instead of pushing.
//   When undefined, no address comparators are built.
//
// Parameters:
//   ADR_WIDTH     node address width
//   PROFUNDIDADE  FIFO depth, power of two, at least 4
//
// Ports:
//   clk                  clock, rising edge
//   rst_n                asynchronous active-low reset
//   req_atualizar_in     update request strobe
//   req_atu_endereco_in  update request node address
//   req_atu_anterior_in  update request predecessor address
//   req_desativar_in     deactivate request strobe
//   req_des_endereco_in  deactivate request node address
//   parar_in             downstream hold, blocks pops
//   fr_pronto_out        at least two free entries
//   atualizar_out        one-cycle update command pulse
//   desativar_out        one-cycle deactivate command pulse
//   endereco_out         address of the last issued command
//   anterior_out         predecessor of the last issued command (0 for desativar)
//   fr_ocupacao_out      number of stored entries
//   fr_vazio_out         queue empty
//   fr_erro_out          sticky, a request was dropped
// -----------------------------------------------------------------------------
module fila_requisicoes #(
    parameter int ADR_WIDTH    = 5,
    parameter int PROFUNDIDADE = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_atualizar_in,
    input  logic [ADR_WIDTH-1:0]              req_atu_endereco_in,
    input  logic [ADR_WIDTH-1:0]              req_atu_anterior_in,
    input  logic                              req_desativar_in,
    input  logic [ADR_WIDTH-1:0]              req_des_endereco_in,
    input  logic                              parar_in,
    output logic                              fr_pronto_out,
    output logic                              atualizar_out,
    output logic                              desativar_out,
    output logic [ADR_WIDTH-1:0]              endereco_out,
    output logic [ADR_WIDTH-1:0]              anterior_out,
    output logic [$clog2(PROFUNDIDADE):0]     fr_ocupacao_out,
    output logic                              fr_vazio_out,
    output logic                              fr_erro_out
);

    localparam int PTR_W = $clog2(PROFUNDIDADE);
    localparam int OCC_W = PTR_W + 1;

    // Entry storage: tipo = 1 means desativar.
    logic                 r_tipo [PROFUNDIDADE];
    logic [ADR_WIDTH-1:0] r_end  [PROFUNDIDADE];
    logic [ADR_WIDTH-1:0] r_ant  [PROFUNDIDADE];

    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [OCC_W-1:0]     r_occ;
    logic                 r_pronto;
    logic                 r_vazio;
    logic                 r_erro;
    logic                 r_atu_out;
    logic                 r_des_out;
    logic [ADR_WIDTH-1:0] r_end_out;
    logic [ADR_WIDTH-1:0] r_ant_out;

    logic                    w_pop;
    logic                    w_acc_des;
    logic                    w_acc_atu;
    logic                    w_push_atu;
    logic                    w_drop;
    logic                    w_coal;
    logic [PROFUNDIDADE-1:0] w_coal_hit;
    logic [1:0]              w_n_push;
    logic [PTR_W-1:0]        w_atu_ptr;
    logic [OCC_W-1:0]        w_occ_next;
    logic [PROFUNDIDADE-1:0] w_wr_des;
    logic [PROFUNDIDADE-1:0] w_wr_atu;

    // Pop only from a non-empty queue while downstream is not holding.
    assign w_pop = (r_occ != '0) && !parar_in;

    // The registered 2-slot margin guarantees both requests of one cycle fit.
    // rst_n gating keeps requests from touching storage while in reset.
    assign w_acc_des = req_desativar_in && r_pronto && rst_n;
    assign w_acc_atu = req_atualizar_in && r_pronto && rst_n;
    assign w_drop    = (req_desativar_in || req_atualizar_in) && !r_pronto;

    assign w_push_atu = w_acc_atu && !w_coal;
    assign w_n_push   = {1'b0, w_acc_des} + {1'b0, w_push_atu};

    // desativar takes the first slot, atualizar the one after it.
    assign w_atu_ptr  = r_wr_ptr + PTR_W'(w_acc_des);
    assign w_occ_next = r_occ + OCC_W'(w_n_push) - OCC_W'(w_pop);

`ifdef FILA_REQUISICOES_COALESCE_EN
    // An entry is "queued" when its distance from the read pointer is below
    // the occupancy; the head leaving this cycle is excluded.
    for (genvar gi = 0; gi < PROFUNDIDADE; gi++) begin : g_coal
        localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
        logic [PTR_W-1:0] w_offset;
        logic             w_queued;
        assign w_offset = IDX - r_rd_ptr;
        assign w_queued = ({1'b0, w_offset} < r_occ) &&
                          !((w_offset == '0) && w_pop);
        assign w_coal_hit[gi] = w_acc_atu && w_queued && !r_tipo[gi] &&
                                (r_end[gi] == req_atu_endereco_in);
    end
    assign w_coal = |w_coal_hit;
`else
    assign w_coal_hit = '0;
    assign w_coal     = 1'b0;
`endif

    // Per-entry write logic; each slot is its own register so two writes
    // (desativar + atualizar) can land in one cycle.
    for (genvar gi = 0; gi < PROFUNDIDADE; gi++) begin : g_mem
        localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
        assign w_wr_des[gi] = w_acc_des  && (r_wr_ptr  == IDX);
        assign w_wr_atu[gi] = w_push_atu && (w_atu_ptr == IDX);

        always_ff @(posedge clk) begin
            if (w_wr_des[gi]) begin
                r_tipo[gi] <= 1'b1;
                r_end[gi]  <= req_des_endereco_in;
                r_ant[gi]  <= '0;
            end else if (w_wr_atu[gi]) begin
                r_tipo[gi] <= 1'b0;
                r_end[gi]  <= req_atu_endereco_in;
                r_ant[gi]  <= req_atu_anterior_in;
            end else if (w_coal_hit[gi]) begin
                r_ant[gi]  <= req_atu_anterior_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_pronto  <= 1'b1;
            r_vazio   <= 1'b1;
            r_erro    <= 1'b0;
            r_atu_out <= 1'b0;
            r_des_out <= 1'b0;
            r_end_out <= '0;
            r_ant_out <= '0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + PTR_W'(w_n_push);
            r_rd_ptr  <= r_rd_ptr + PTR_W'(w_pop);
            r_occ     <= w_occ_next;
            r_vazio   <= (w_occ_next == '0);
            r_pronto  <= (w_occ_next <= OCC_W'(PROFUNDIDADE - 2));
            r_erro    <= r_erro | w_drop;
            r_atu_out <= w_pop && !r_tipo[r_rd_ptr];
            r_des_out <= w_pop &&  r_tipo[r_rd_ptr];
            if (w_pop) begin
                r_end_out <= r_end[r_rd_ptr];
                r_ant_out <= r_ant[r_rd_ptr];
            end
        end
    end

    assign fr_pronto_out   = r_pronto;
    assign atualizar_out   = r_atu_out;
    assign desativar_out   = r_des_out;
    assign endereco_out    = r_end_out;
    assign anterior_out    = r_ant_out;
    assign fr_ocupacao_out = r_occ;
    assign fr_vazio_out    = r_vazio;
    assign fr_erro_out     = r_erro;

endmodule

// File: tb/tb_fila_requisicoes.sv
// -----------------------------------------------------------------------------
// tb_fila_requisicoes
//
// Directed scenarios followed by randomized traffic, every cycle compared to a
// queue-based reference model of the request FIFO. Coalescing expectations
// follow the FILA_REQUISICOES_COALESCE_EN macro.
// -----------------------------------------------------------------------------
module tb_fila_requisicoes;

    localparam int AW   = 5;
    localparam int PROF = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_atualizar;
    logic [AW-1:0] req_atu_end;
    logic [AW-1:0] req_atu_ant;
    logic          req_desativar;
    logic [AW-1:0] req_des_end;
    logic          parar;
    logic          pronto;
    logic          atu_out;
    logic          des_out;
    logic [AW-1:0] end_out;
    logic [AW-1:0] ant_out;
    logic [3:0]    ocupacao;
    logic          vazio;
    logic          erro;

    fila_requisicoes #(.ADR_WIDTH(AW), .PROFUNDIDADE(PROF)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_atualizar_in    (req_atualizar),
        .req_atu_endereco_in (req_atu_end),
        .req_atu_anterior_in (req_atu_ant),
        .req_desativar_in    (req_desativar),
        .req_des_endereco_in (req_des_end),
        .parar_in            (parar),
        .fr_pronto_out       (pronto),
        .atualizar_out       (atu_out),
        .desativar_out       (des_out),
        .endereco_out        (end_out),
        .anterior_out        (ant_out),
        .fr_ocupacao_out     (ocupacao),
        .fr_vazio_out        (vazio),
        .fr_erro_out         (erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            tipo;
        logic [AW-1:0] ende;
        logic [AW-1:0] ant;
    } ent_t;

    ent_t          q[$];
    bit            exp_atu, exp_des, exp_erro;
    logic [AW-1:0] exp_end, exp_ant;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " atualizar_out"}, {31'd0, atu_out}, {31'd0, exp_atu});
        check({tag, " desativar_out"}, {31'd0, des_out}, {31'd0, exp_des});
        check({tag, " endereco_out"}, {27'd0, end_out}, {27'd0, exp_end});
        check({tag, " anterior_out"}, {27'd0, ant_out}, {27'd0, exp_ant});
        check({tag, " ocupacao"}, {28'd0, ocupacao}, q.size());
        check({tag, " vazio"}, {31'd0, vazio}, (q.size() == 0) ? 1 : 0);
        check({tag, " pronto"}, {31'd0, pronto}, ((PROF - q.size()) >= 2) ? 1 : 0);
        check({tag, " erro"}, {31'd0, erro}, {31'd0, exp_erro});
    endtask

    // Reference model: behaviour of one clock edge, using pre-edge state.
    task automatic model_step();
        bit   can_accept;
        bit   merged;
        ent_t h;
        can_accept = (PROF - q.size()) >= 2;
        exp_atu = 1'b0;
        exp_des = 1'b0;
        if (q.size() > 0 && !parar) begin
            h = q.pop_front();
            exp_atu = !h.tipo;
            exp_des = h.tipo;
            exp_end = h.ende;
            exp_ant = h.ant;
        end
        if (can_accept) begin
            if (req_desativar) q.push_back('{1'b1, req_des_end, '0});
            if (req_atualizar) begin
                merged = 1'b0;
`ifdef FILA_REQUISICOES_COALESCE_EN
                foreach (q[k]) begin
                    if (!q[k].tipo && q[k].ende == req_atu_end) begin
                        q[k].ant = req_atu_ant;
                        merged = 1'b1;
                    end
                end
`endif
                if (!merged) q.push_back('{1'b0, req_atu_end, req_atu_ant});
            end
        end else if (req_atualizar || req_desativar) begin
            exp_erro = 1'b1;
        end
    endtask

    task automatic cycle(input string tag, input bit atu, input logic [AW-1:0] ae,
                         input logic [AW-1:0] aa, input bit des,
                         input logic [AW-1:0] de, input bit par);
        req_atualizar = atu;
        req_atu_end   = ae;
        req_atu_ant   = aa;
        req_desativar = des;
        req_des_end   = de;
        parar         = par;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        exp_atu  = 1'b0;
        exp_des  = 1'b0;
        exp_end  = '0;
        exp_ant  = '0;
        exp_erro = 1'b0;
    endtask

    initial begin
        int pct;
        rst_n = 1'b0;
        req_atualizar = 1'b0; req_atu_end = '0; req_atu_ant = '0;
        req_desativar = 1'b0; req_des_end = '0; parar = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Single atualizar: pulse in the next cycle, queue back to empty.
        cycle("atu5", 1, 5'd5, 5'd2, 0, 5'd0, 0);
        check("atu5 occ1", {28'd0, ocupacao}, 1);
        cycle("atu5 issue", 0, 0, 0, 0, 0, 0);
        check("atu5 pulse", {31'd0, atu_out}, 1);
        check("atu5 end", {27'd0, end_out}, 5);
        check("atu5 ant", {27'd0, ant_out}, 2);
        cycle("idle", 0, 0, 0, 0, 0, 0);

        // Simultaneous requests: desativar first.
        cycle("both", 1, 5'd9, 5'd3, 1, 5'd7, 0);
        check("both occ2", {28'd0, ocupacao}, 2);
        cycle("both issue1", 0, 0, 0, 0, 0, 0);
        check("both des first", {31'd0, des_out}, 1);
        check("both des addr", {27'd0, end_out}, 7);
        cycle("both issue2", 0, 0, 0, 0, 0, 0);
        check("both atu second", {31'd0, atu_out}, 1);
        cycle("idle", 0, 0, 0, 0, 0, 0);

        // Same-address atualizar while held.
        cycle("coal a", 1, 5'd4, 5'd1, 0, 0, 1);
        cycle("coal b", 1, 5'd4, 5'd6, 0, 0, 1);
        repeat (3) cycle("coal drain", 0, 0, 0, 0, 0, 0);

        // Fill to 7 while held, drop the 8th, then drain in order.
        for (int i = 0; i < 7; i++)
            cycle("fill", 1, AW'(10 + i), AW'(i), 0, 0, 1);
        check("fill pronto low", {31'd0, pronto}, 0);
        cycle("drop", 1, 5'd30, 5'd30, 0, 0, 1);
        check("drop erro", {31'd0, erro}, 1);
        for (int i = 0; i < 8; i++)
            cycle("drain", 0, 0, 0, 0, 0, 0);

        // Reset with 3 queued and a pulse in flight.
        for (int i = 0; i < 4; i++)
            cycle("pre-rst", 1, AW'(20 + i), AW'(i), 0, 0, 1);
        cycle("pre-rst pop", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("async rst");
        req_atualizar = 1'b1; req_desativar = 1'b1; parar = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("held rst");
        req_atualizar = 1'b0; req_desativar = 1'b0;
        rst_n = 1'b1;
        repeat (4) cycle("post-rst", 0, 0, 0, 0, 0, 0);

        // Randomized traffic with alternating hold pressure.
        for (int n = 0; n < 3000; n++) begin
            pct = ((n / 200) % 2 == 0) ? 30 : 75;
            cycle("rand",
                  $urandom_range(0, 1) == 1, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 31)),
                  $urandom_range(0, 3) == 0, AW'($urandom_range(0, 31)),
                  $urandom_range(0, 99) < pct);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
